// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: byte-stream front end for an AES core. Packs 16 input bytes
// into a block, pulses start with key/mode, waits for done, streams 16 bytes out.
// Latency: start the cycle after the 16th byte; first output byte the cycle after done.
// Backpressure: o_InReady low outside COLLECT; output bytes hold while i_OutReady is low.
//
// Ports:
//   i_Clk, i_Rst                         clock, synchronous active-high reset
//   i_InByte/i_InValid/o_InReady         byte input handshake
//   o_OutByte/o_OutValid/i_OutReady      byte output handshake
//   i_Key, i_fEnc                        key and mode, latched with the 16th input byte
//   o_AesStart/o_AesEnc/o_AesText/o_AesKey  request to the AES core
//   i_AesData, i_AesDone                 result from the AES core
//   o_fBusy                              block in flight (START, WAIT or EMIT)
//   o_fTimeout                           sticky: core did not finish in TIMEOUT_CYC cycles
module aes_stream_ctrl #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [127:0] i_Key,
  input  logic         i_fEnc,
  input  logic [7:0]   i_InByte,
  input  logic         i_InValid,
  output logic         o_InReady,
  output logic [7:0]   o_OutByte,
  output logic         o_OutValid,
  input  logic         i_OutReady,
  output logic         o_AesStart,
  output logic         o_AesEnc,
  output logic [127:0] o_AesText,
  output logic [127:0] o_AesKey,
  input  logic [127:0] i_AesData,
  input  logic         i_AesDone,
  output logic         o_fBusy,
  output logic         o_fTimeout
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [3:0]       byte_cnt;   // input byte index in COLLECT, output byte index in EMIT
  logic [CNT_W-1:0] tmo_cnt;
  logic [127:0]     out_sr;     // bytes still to be emitted after o_OutByte, MSB first

  assign o_InReady = (state == S_COLLECT);
  assign o_fBusy   = (state != S_COLLECT);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= S_COLLECT;
      byte_cnt   <= 4'd0;
      tmo_cnt    <= '0;
      out_sr     <= '0;
      o_AesStart <= 1'b0;
      o_AesEnc   <= 1'b1;
      o_AesText  <= '0;
      o_AesKey   <= '0;
      o_OutByte  <= 8'd0;
      o_OutValid <= 1'b0;
      o_fTimeout <= 1'b0;
    end else begin
      o_AesStart <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (i_InValid) begin
            // Byte k lands at [127-8k -: 8]; ~byte_cnt is 15-k for a 4-bit count.
            o_AesText[{~byte_cnt, 3'b000} +: 8] <= i_InByte;
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              o_AesKey   <= i_Key;
              o_AesEnc   <= i_fEnc;
              o_AesStart <= 1'b1;
              o_fTimeout <= 1'b0;
              state      <= S_START;
            end
          end
        end
        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over a timeout expiring on the same cycle.
          if (i_AesDone) begin
            o_OutByte  <= i_AesData[127:120];
            out_sr     <= {i_AesData[119:0], 8'h00};
            o_OutValid <= 1'b1;
            byte_cnt   <= 4'd0;
            state      <= S_EMIT;
          end else if (tmo_cnt == TMO_LAST) begin
            o_fTimeout <= 1'b1;
            byte_cnt   <= 4'd0;
            state      <= S_COLLECT;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (i_OutReady) begin
            if (byte_cnt == 4'd15) begin
              o_OutValid <= 1'b0;
              byte_cnt   <= 4'd0;
              state      <= S_COLLECT;
            end else begin
              byte_cnt  <= byte_cnt + 4'd1;
              o_OutByte <= out_sr[127:120];
              out_sr    <= {out_sr[119:0], 8'h00};
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: randomized bench with a transaction-level reference model
// and a stand-in AES core (XOR-based) with programmable or random done latency.
// Outputs are compared on every falling edge; directed blocks pin the model.
module tb_aes_stream_ctrl;

  localparam int TMO = 8;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic [127:0] i_Key;
  logic         i_fEnc;
  logic [7:0]   i_InByte;
  logic         i_InValid;
  logic         o_InReady;
  logic [7:0]   o_OutByte;
  logic         o_OutValid;
  logic         i_OutReady;
  logic         o_AesStart;
  logic         o_AesEnc;
  logic [127:0] o_AesText;
  logic [127:0] o_AesKey;
  logic [127:0] i_AesData;
  logic         i_AesDone;
  logic         o_fBusy;
  logic         o_fTimeout;

  always #5 i_Clk = ~i_Clk;

  aes_stream_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(4)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Key(i_Key), .i_fEnc(i_fEnc),
    .i_InByte(i_InByte), .i_InValid(i_InValid), .o_InReady(o_InReady),
    .o_OutByte(o_OutByte), .o_OutValid(o_OutValid), .i_OutReady(i_OutReady),
    .o_AesStart(o_AesStart), .o_AesEnc(o_AesEnc), .o_AesText(o_AesText),
    .o_AesKey(o_AesKey), .i_AesData(i_AesData), .i_AesDone(i_AesDone),
    .o_fBusy(o_fBusy), .o_fTimeout(o_fTimeout)
  );

  // Reference model: what the block must look like, in terms of bytes held and queued.
  int           m_nin;      // bytes gathered into the current block
  logic [127:0] m_blk;
  logic [127:0] m_key;
  logic         m_enc;
  logic         m_start;    // this cycle is the start cycle
  int           m_wait;     // WAIT cycles already elapsed, -1 when not waiting
  logic         m_tmo;
  logic [7:0]   m_q[$];     // bytes still owed downstream, head is on the bus
  int           lat;        // done arrives on this WAIT cycle (1-based)
  int           next_lat;   // 0: random latency for the next block
  logic [7:0]   cap[$];     // bytes that actually transferred

  int n_cmp;
  int n_err;

  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k,
                                           input logic e);
    return e ? (t ^ k) : ~(t ^ k);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_nin   = 0;
    m_blk   = '0;
    m_key   = '0;
    m_enc   = 1'b1;
    m_start = 1'b0;
    m_wait  = -1;
    m_tmo   = 1'b0;
    m_q.delete();
  endtask

  function automatic logic collecting();
    return !m_start && (m_wait < 0) && (m_q.size() == 0);
  endfunction

  task automatic check_outputs();
    logic col;
    col = collecting();
    chk("in_ready", {127'd0, o_InReady}, {127'd0, col});
    chk("busy", {127'd0, o_fBusy}, {127'd0, !col});
    chk("start", {127'd0, o_AesStart}, {127'd0, m_start});
    chk("out_valid", {127'd0, o_OutValid}, {127'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("out_byte", {120'd0, o_OutByte}, {120'd0, m_q[0]});
    chk("timeout", {127'd0, o_fTimeout}, {127'd0, m_tmo});
    chk("text", o_AesText, m_blk);
    chk("key", o_AesKey, m_key);
    chk("enc", {127'd0, o_AesEnc}, {127'd0, m_enc});
  endtask

  // One clock cycle: check the current outputs, drive inputs for the next edge,
  // then advance the model across that edge.
  task automatic step(input logic rst, input logic vld, input logic [7:0] b,
                      input logic [127:0] key, input logic enc, input logic ordy,
                      input logic stray);
    logic         dn;
    logic [127:0] res;
    @(negedge i_Clk);
    check_outputs();
    i_Rst      = rst;
    i_InValid  = vld;
    i_InByte   = b;
    i_Key      = key;
    i_fEnc     = enc;
    i_OutReady = ordy;
    if (m_wait >= 0) dn = (m_wait + 1 == lat);
    else             dn = stray && ($urandom_range(0, 15) == 0);
    i_AesDone = dn;
    i_AesData = dn ? core_fn(o_AesText, o_AesKey, o_AesEnc)
                   : {$urandom(), $urandom(), $urandom(), $urandom()};
    if (o_OutValid && ordy && !rst) cap.push_back(o_OutByte);

    if (rst) begin
      model_reset();
    end else if (collecting()) begin
      if (vld) begin
        m_blk[127 - 8*m_nin -: 8] = b;
        m_nin++;
        if (m_nin == 16) begin
          m_nin   = 0;
          m_key   = key;
          m_enc   = enc;
          m_start = 1'b1;
          m_tmo   = 1'b0;
        end
      end
    end else if (m_start) begin
      m_start = 1'b0;
      m_wait  = 0;
      lat     = (next_lat > 0) ? next_lat : $urandom_range(1, TMO + 2);
    end else if (m_wait >= 0) begin
      if (dn) begin
        res = core_fn(m_blk, m_key, m_enc);
        for (int i = 0; i < 16; i++) m_q.push_back(res[127 - 8*i -: 8]);
        m_wait = -1;
      end else if (m_wait + 1 == TMO) begin
        m_tmo  = 1'b1;
        m_wait = -1;
      end else begin
        m_wait++;
      end
    end else if (ordy) begin
      void'(m_q.pop_front());
    end
  endtask

  task automatic feed_block(input logic [7:0] base, input logic [127:0] key, input logic enc);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, base + 8'(i), key, enc, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n, input logic [127:0] key);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, key, 1'b1, 1'b1, 1'b0);
  endtask

  localparam logic [127:0] K10 = {16{8'h10}};

  initial begin
    n_cmp = 0;
    n_err = 0;
    next_lat = 0;
    lat = 1;
    i_Rst = 1'b1; i_Key = '0; i_fEnc = 1'b0; i_InByte = 8'h00; i_InValid = 1'b1;
    i_OutReady = 1'b0; i_AesData = '0; i_AesDone = 1'b1;
    repeat (2) @(posedge i_Clk);
    model_reset();
    @(negedge i_Clk);
    chk("rst_enc", {127'd0, o_AesEnc}, 128'd1);
    chk("rst_text", o_AesText, 128'd0);
    chk("rst_key", o_AesKey, 128'd0);
    chk("rst_valid", {127'd0, o_OutValid}, 128'd0);
    chk("rst_ready", {127'd0, o_InReady}, 128'd1);
    chk("rst_tmo", {127'd0, o_fTimeout}, 128'd0);

    // Encrypt, quickest core, downstream always ready: bytes i ^ 0x10.
    next_lat = 1;
    cap.delete();
    feed_block(8'h00, K10, 1'b1);
    idle(20, K10);
    chk("enc_count", 128'(cap.size()), 128'd16);
    for (int i = 0; i < cap.size(); i++) chk("enc_byte", {120'd0, cap[i]}, 128'h10 + 128'(i));

    // Decrypt, done on the last legal WAIT cycle, ready pattern 1,0,0: bytes ~i.
    next_lat = TMO;
    cap.delete();
    feed_block(8'h00, 128'd0, 1'b0);
    for (int j = 0; j < 70; j++) step(1'b0, 1'b0, 8'h00, 128'd0, 1'b1, (j % 3) == 0, 1'b0);
    chk("dec_count", 128'(cap.size()), 128'd16);
    for (int i = 0; i < cap.size(); i++) chk("dec_byte", {120'd0, cap[i]}, 128'hFF - 128'(i));

    // Core never answers: flag after TMO WAIT cycles, back to accepting input.
    next_lat = 1000;
    feed_block(8'h30, K10, 1'b1);
    idle(TMO + 2, K10);
    chk("tmo_flag", {127'd0, o_fTimeout}, 128'd1);
    chk("tmo_ready", {127'd0, o_InReady}, 128'd1);
    chk("tmo_valid", {127'd0, o_OutValid}, 128'd0);
    next_lat = 2;
    feed_block(8'h40, K10, 1'b1);
    idle(1, K10);
    chk("tmo_clear", {127'd0, o_fTimeout}, 128'd0);
    chk("tmo_start", {127'd0, o_AesStart}, 128'd1);
    idle(30, K10);

    // Reset part-way through a block; the next 16 bytes form a fresh block.
    next_lat = 1;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h55, K10, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h66, K10, 1'b1, 1'b1, 1'b0);
    cap.delete();
    feed_block(8'hA0, 128'd0, 1'b1);
    idle(20, 128'd0);
    chk("rst_blk_count", 128'(cap.size()), 128'd16);
    for (int i = 0; i < cap.size(); i++) chk("rst_blk_byte", {120'd0, cap[i]}, 128'hA0 + 128'(i));

    // Reset while output is stalled.
    feed_block(8'h00, K10, 1'b1);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 8'h00, K10, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, K10, 1'b1, 1'b0, 1'b0);
    idle(1, K10);
    chk("emit_rst_valid", {127'd0, o_OutValid}, 128'd0);

    // Random traffic with stray done pulses, random latency and occasional resets.
    next_lat = 0;
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 7, 8'($urandom()),
           {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom()),
           ((c / 200) % 2 == 0) ? 1'b1 : 1'($urandom()), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
